// File: rtl/mem_io_bridge.sv
// mem_io_bridge: memory and I/O slave on the core's data port.
// Decodes dataadr into a doubleword RAM and an I/O page (TXDATA, STATUS,
// CYCLE), returns readdata combinationally, and feeds a byte-wide TX FIFO.
// Optional feature macro: MEMIO_CYCLECNT_EN enables the 64-bit cycle counter;
// without it CYCLE reads 0 and stores to it are ignored.
module mem_io_bridge #(
    parameter int N         = 64,
    parameter int MEMWORDS  = 256,
    parameter int FIFODEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] dataadr,
    input  logic [N-1:0] writedata,
    input  logic [1:0]   memwrite,
    input  logic         dtype,
    output logic [N-1:0] readdata,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready
);

    localparam int AW = $clog2(MEMWORDS);
    localparam int PW = $clog2(FIFODEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFODEPTH);
    localparam logic [11:0]   OFF_TXDATA = 12'hF00;
    localparam logic [11:0]   OFF_STATUS = 12'hF08;
    localparam logic [11:0]   OFF_CYCLE  = 12'hF10;

    // Address decode and request classification
    logic          is_io;
    logic [11:0]   off;
    logic [AW-1:0] idx;
    logic          store;
    logic          bad_op;
    logic          unused_adr;

    assign is_io      = &dataadr[N-1:12];
    assign off        = dataadr[11:0];
    assign idx        = dataadr[AW+2:3];
    assign store      = (memwrite == 2'b01) || (memwrite == 2'b10);
    assign bad_op     = (memwrite == 2'b11);
    assign unused_adr = ^dataadr[1:0];

    // RAM storage (contents intentionally not reset)
    logic [N-1:0] mem_q [MEMWORDS];

    // RAM write port: doubleword store or single 32-bit lane store
    always_ff @(posedge clk) begin
        if (!is_io) begin
            if (memwrite == 2'b10) begin
                mem_q[idx] <= writedata;
            end else if (memwrite == 2'b01) begin
                if (dataadr[2]) begin
                    mem_q[idx][32 +: 32] <= writedata[31:0];
                end else begin
                    mem_q[idx][0 +: 32] <= writedata[31:0];
                end
            end
        end
    end

    // FIFO and sticky status state
    logic [7:0]    buf_q [FIFODEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          push, pop, accept, full, empty;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign tx_valid = !empty;
    assign tx_data  = buf_q[rd_ptr_q];

    // Next-state for FIFO pointers/count and sticky overflow/err flags
    always_comb begin
        push     = is_io && (off == OFF_TXDATA) && store;
        pop      = tx_valid && tx_ready;
        accept   = push && (!full || pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CW'(1);
        end
        if (push && !accept) begin
            ovf_d = 1'b1;
        end
        if (bad_op) begin
            err_d = 1'b1;
        end
        if (is_io && (off == OFF_STATUS) && store) begin
            ovf_d = 1'b0;
            err_d = 1'b0;
        end
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // FIFO byte storage; cleared on reset so tx_data reads 0 out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFODEPTH; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else if (accept) begin
            buf_q[wr_ptr_q] <= writedata[7:0];
        end
    end

    // Cycle counter (optional)
    logic [N-1:0] cyc_val;
`ifdef MEMIO_CYCLECNT_EN
    logic [N-1:0] cyc_q, cyc_d;

    // A store to CYCLE wins over the increment
    always_comb begin
        cyc_d = cyc_q + N'(1);
        if (is_io && (off == OFF_CYCLE) && store) begin
            cyc_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cyc_val = cyc_q;
`else
    assign cyc_val = '0;
`endif

    // Read path: select source, then doubleword or zero-extended 32-bit lane
    logic [N-1:0] io_rd;
    logic [N-1:0] raw;

    always_comb begin
        io_rd = '0;
        case (off)
            OFF_STATUS: begin
                io_rd[3:0]  = {err_q, ovf_q, full, empty};
                io_rd[15:8] = 8'(count_q);
            end
            OFF_CYCLE: io_rd = cyc_val;
            default:   io_rd = '0;
        endcase
        raw = is_io ? io_rd : mem_q[idx];
        if (dtype) begin
            readdata = raw;
        end else begin
            readdata = {{(N-32){1'b0}}, (dataadr[2] ? raw[32 +: 32] : raw[0 +: 32])};
        end
    end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Memory and I/O slave on the CPU core's data/instruction port: decodes the core's `dataadr` into a doubleword RAM region and a small I/O register page. It serves RAM reads and writes and drives a byte-wide transmit FIFO toward an external sink. It also provides a free-running cycle counter. It sits directly downstream of the core and returns `readdata` in the same cycle, as the multicycle core requires.

## Interface
- `N`, 64, data/address width.
- `MEMWORDS`, 256, RAM depth in 64-bit doublewords (power of two).
- `FIFODEPTH`, 8, TX FIFO depth in bytes (power of two, ≥2).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dataadr`  in  N  byte address from core.
- `writedata`  in  N  store data from core.
- `memwrite`  in  2  00 none, 01 word store, 10 doubleword store, 11 reserved.
- `dtype`  in  1  read width: 1 doubleword, 0 word.
- `readdata`  out  N  combinational read data.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  sink accepts head byte.

## Operation
- Decode: `dataadr[N-1:12]` all ones → I/O page; else RAM, index `dataadr[log2(MEMWORDS)+2:3]` (upper bits ignored, aliasing).
- RAM read: `dtype`=1 → full doubleword; `dtype`=0 → 32-bit lane chosen by `dataadr[2]` (1 = upper), zero-extended into `readdata[31:0]`.
- RAM write: `memwrite`=01 writes only the lane chosen by `dataadr[2]` with `writedata[31:0]`; 10 writes all 64 bits; 11 writes nothing and sets sticky `err`.
- I/O registers (offset = `dataadr[11:0]`):
  - 0xF00 TXDATA: any store pushes `writedata[7:0]`; read returns 0.
  - 0xF08 STATUS (read-only): bit0 empty, bit1 full, bit2 overflow (sticky), bit3 err (sticky), bits[15:8] count; store to STATUS clears overflow and err.
  - 0xF10 CYCLE: read returns 64-bit counter; any store zeroes it.
  - Other offsets: read 0, stores ignored.
- Word reads of I/O apply the same lane selection as RAM.
- FIFO: push on TXDATA store; pop when `tx_valid && tx_ready`. Push accepted if count<FIFODEPTH, or if a pop occurs the same cycle. Otherwise byte is dropped and overflow is set. Pointers wrap modulo FIFODEPTH; count spans 0..FIFODEPTH.
- Simultaneous push+pop: count unchanged, head advances, new byte written at tail.
- Cycle counter: +1 every cycle, wraps 2^64−1 → 0; store takes priority over increment.

## Timing
- Reads: zero latency, purely combinational from `dataadr`/`dtype` and current state.
- Writes: take effect at the rising edge where `memwrite`≠0; visible to reads in the next cycle.
- TX handshake: `tx_data`/`tx_valid` registered state; held stable until popped. A pushed byte appears on `tx_valid` the cycle after the push edge.
- Reset (asserted low, asynchronous): FIFO empty, `tx_valid`=0, `tx_data`=0, counter=0, overflow=0, err=0. RAM contents are not reset. `readdata` reflects reset register values immediately.
- Reset mid-transfer: un-popped bytes are discarded; no pop is reported.
- Counter reads 0 in the cycle after a CYCLE store edge, 1 the following cycle.

## Configuration
- `MEMIO_CYCLECNT_EN` defined: cycle counter implemented as above.
- Not defined: no counter flops. CYCLE reads 0, and stores to CYCLE are ignored. All other behaviour is identical.

## Test plan
- Doubleword store 0x1122334455667788 @0x10, then word store 0xAABBCCDD @0x14 → `dtype`=1 read @0x10 returns 0xAABBCCDD55667788; `dtype`=0 read @0x10 returns 0x0000000055667788.
- `memwrite`=11 @0x20 → RAM unchanged; STATUS bit3=1; store to STATUS → bit3=0.
- With `tx_ready`=0, push 9 bytes 0x01..0x09 → count=8, full=1, overflow=1. Raise `tx_ready` → bytes 0x01..0x08 are emitted one per cycle; then empty=1 and `tx_valid`=0.
- FIFO full with `tx_ready`=1 plus a push of 0x55 in the same cycle → accepted, count stays 8, overflow stays 0; 0x55 is emitted last.
- Store CYCLE, then read for 3 cycles → 0, 1, 2. Drive reset low mid-run → counter=0 and `tx_valid`=0 immediately, without waiting for a clock edge.
- Build without `MEMIO_CYCLECNT_EN` → CYCLE read returns 0 after 100 cycles; store has no effect.
